// File: rtl/seq_ctrl_pkg.sv
// Shared state encoding and width helper for the sequence detector controller.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_MATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bits needed to hold a pattern length in 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_window_match.sv
// Serial window shift register with fill counter and a look-ahead compare:
// hit_o reports that the window *after* this edge's shift equals the pattern.
module seq_window_match
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       shift_i,
    input  logic                       x_i,
    input  logic [MAX_LEN-1:0]         pattern_i,
    input  logic [len_w(MAX_LEN)-1:0]  len_i,
    output logic                       hit_o
);
    localparam int LW = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] window_q, window_d, window_nxt, mask;
    logic [LW-1:0]      fill_q, fill_d, fill_nxt;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        window_d   = window_q;
        fill_d     = fill_q;
        window_nxt = MAX_LEN'({window_q, x_i});
        fill_nxt   = (fill_q >= len_i) ? len_i : fill_q + LW'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_i));
        end
        hit_o = shift_i && (fill_nxt == len_i) && (((window_nxt ^ pattern_i) & mask) == '0);

        // Clear wins over shift so the completing bit of a match never leaks into the next window.
        if (clear_i) begin
            window_d = '0;
            fill_d   = '0;
        end else if (shift_i) begin
            window_d = window_nxt;
            fill_d   = fill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples values from before the edge.
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable, non-overlapping Moore pattern detector.
// Optional run timeout is built only when SEQ_TIMEOUT_EN is defined.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN     = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [MAX_LEN-1:0]        cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0] cfg_len,
    input  logic [CNT_W-1:0]          cfg_target,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      x,
    input  logic                      x_valid,
    output logic                      z,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      timeout
);
    localparam int LW = len_w(MAX_LEN);

    if (MAX_LEN < 1) begin : g_bad_max_len
        $error("MAX_LEN must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]      len_q, len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q;
    logic               hit, expired, cfg_open, win_clear, win_shift;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == '0) return LW'(1);
        if (int'(l) > MAX_LEN) return LW'(MAX_LEN);
        return l;
    endfunction

    assign cfg_open  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign win_shift = x_valid && ((state_q == ST_RUN) || (state_q == ST_MATCH));
    assign win_clear = (state_d == ST_ARM) || (state_d == ST_MATCH);

    seq_window_match #(.MAX_LEN(MAX_LEN)) u_window (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (win_clear),
        .shift_i   (win_shift),
        .x_i       (x),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .hit_o     (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= LW'(1);
            target_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_ARM;
                ST_ARM:           state_d = ST_RUN;
                ST_RUN: begin
                    if (hit)          state_d = ST_MATCH;
                    else if (expired) state_d = ST_DONE;
                end
                ST_MATCH: begin
                    // Reaching the target ends the run even if this cycle's bit would match.
                    if (target_q != '0 && cnt_q == target_q) state_d = ST_DONE;
                    else if (hit)                            state_d = ST_MATCH;
                    else                                     state_d = ST_RUN;
                end
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        // Loading before ARM lets a simultaneous start run with the new config.
        if (cfg_we && cfg_open && !abort) begin
            pattern_d = cfg_pattern;
            len_d     = clamp_len(cfg_len);
            target_d  = cfg_target;
        end
        if (state_d == ST_ARM) begin
            cnt_d = '0;
        end else if (state_d == ST_MATCH && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] run_cyc_q, run_cyc_d;
    logic          tmo_d;

    assign expired = (state_q == ST_RUN) && (run_cyc_q + TW'(1) == TW'(TIMEOUT_CYC));

    always_comb begin
        run_cyc_d = run_cyc_q;
        tmo_d     = tmo_q;
        if (state_d == ST_ARM || state_d == ST_MATCH) begin
            run_cyc_d = '0;
        end else if (state_q == ST_RUN) begin
            run_cyc_d = run_cyc_q + TW'(1);
        end
        if (state_d == ST_ARM) begin
            tmo_d = 1'b0;
        end else if (state_q == ST_RUN && state_d == ST_DONE) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cyc_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            run_cyc_q <= run_cyc_d;
            tmo_q     <= tmo_d;
        end
    end
`else
    assign expired = 1'b0;
    assign tmo_q   = 1'b0;
`endif

    always_comb begin
        z         = (state_q == ST_MATCH);
        busy      = state_q inside {ST_ARM, ST_RUN, ST_MATCH};
        done      = (state_q == ST_DONE);
        match_cnt = cnt_q;
        timeout   = tmo_q;
    end

endmodule
